// File: rtl/display_pkg.sv
// display_pkg: shared constants and anode helper for the seven-segment scan driver.
package display_pkg;
  localparam int NIB_W = 4;
  localparam int MAX_DIGITS = 8;
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;
  function automatic logic [MAX_DIGITS-1:0] onehot_low(input int unsigned idx, input int unsigned digits);
    return ~((MAX_DIGITS'(1) << idx) & ((MAX_DIGITS'(1) << digits) - MAX_DIGITS'(1)));
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler: free-running 0..DIV-1 counter with a terminal-count strobe.
module scan_prescaler #(
  parameter int DIV = 50000
) (
  input  logic CLK,
  input  logic RST,
  output logic tc
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(DIV - 1);
  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed digit scanner with a one-deep pending word buffer.
// Define SCAN_BLANK_EN to blank leading-zero digits (digit 0 always lit).
module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NIB_W*DIGITS-1:0] data_in,
  input  logic                    load,
  output logic                    ready,
  output logic [NIB_W-1:0]        value,
  output logic [DIGITS-1:0]       an,
  output logic                    frame_tick
);
  localparam int IW = $clog2(DIGITS);
  logic [DIGITS-1:0][NIB_W-1:0] pending, active, src;
  logic [IW-1:0] idx, nidx;
  logic [DIGITS-1:0] lit, an_sel;
  logic pend_valid, tc, wrap, transfer;
  scan_prescaler #(.DIV(REFRESH_DIV)) u_pre (.CLK(CLK), .RST(RST), .tc(tc));
  // At a transfer edge the new frame must already show the incoming word.
  always_comb begin
    wrap = tc && idx == IW'(DIGITS - 1);
    transfer = wrap && pend_valid;
    nidx = wrap ? '0 : idx + 1'b1;
    src = transfer ? pending : active;
    an_sel = DIGITS'(onehot_low(32'(nidx), DIGITS));
    ready = ~pend_valid;
    lit = '1;
`ifdef SCAN_BLANK_EN
    lit[DIGITS-1] = |src[DIGITS-1];
    for (int i = DIGITS - 2; i > 0; i--) lit[i] = lit[i+1] | (|src[i]);
`endif
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      idx <= '0;
      pending <= '0;
      active <= '0;
      pend_valid <= 1'b0;
      value <= '0;
      an <= AN_OFF[DIGITS-1:0];
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (tc) begin
        idx <= nidx;
        value <= src[nidx];
        an <= lit[nidx] ? an_sel : AN_OFF[DIGITS-1:0];
      end
      if (load && !pend_valid) begin
        pending <= data_in;
        pend_valid <= 1'b1;
      end else if (transfer) begin
        active <= pending;
        pend_valid <= 1'b0;
      end
    end
endmodule
